i2c_mmio_bridge: RTL and testbench

//  Upstream feeder for the I2C transaction controller. Turns CPU memory-mapped

---
 rtl/i2c_mmio_bridge.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_mmio_bridge.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_mmio_bridge.sv
// CPU memory-mapped front end for the I2C transaction controller: queues CMD
// writes in a small FIFO, runs the NEWMSG/CLR_NM handshake and reports status.
module i2c_mmio_bridge #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic        SYS_CLOCK,
    input  logic        RST,
    input  logic        SEL,
    input  logic [1:0]  REG_ADDR,
    input  logic        WR_EN,
    input  logic        RD_EN,
    input  logic [31:0] WR_DATA,
    output logic [31:0] RD_DATA,
    output logic [7:0]  MOSI,
    output logic [6:0]  SLAVE_ADDR,
    output logic        RW,
    output logic        NEWMSG,
    input  logic [7:0]  MISO,
    input  logic        CLR_NM,
    output logic        IRQ
);

    localparam int unsigned PTR_W   = (CNT_W > 1) ? CNT_W - 1 : 1;
    localparam int unsigned ENTRY_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_CLR,
        ST_WAIT_REL
    } state_e;

    state_e             state_q, state_d;
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         mosi_q, mosi_d;
    logic [6:0]         addr_q, addr_d;
    logic               rw_q, rw_d;
    logic               newmsg_q, newmsg_d;
    logic [7:0]         rxdata_q, rxdata_d;
    logic               rx_valid_q, rx_valid_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               irq_en_q, irq_en_d;
    logic               irq_q, irq_d;
    logic [31:0]        rd_data_q, rd_data_d;

    logic               cmd_wr_c, status_wr_c, ctrl_wr_c, rd_c, rxdata_rd_c;
    logic               full_c, empty_c, push_c, pop_c, clr_evt_c;
    logic [ENTRY_W-1:0] head_c;
    logic               unused_c;

    assign unused_c = ^WR_DATA[31:16];

    // Bus decode and FIFO status
    always_comb begin
        cmd_wr_c    = SEL & WR_EN & (REG_ADDR == 2'd0);
        status_wr_c = SEL & WR_EN & (REG_ADDR == 2'd1);
        ctrl_wr_c   = SEL & WR_EN & (REG_ADDR == 2'd3);
        rd_c        = SEL & RD_EN;
        rxdata_rd_c = rd_c & (REG_ADDR == 2'd2);
        full_c      = (count_q == CNT_W'(FIFO_DEPTH));
        empty_c     = (count_q == '0);
        // Fullness is judged before the edge, so a same-cycle pop never rescues a push
        push_c      = cmd_wr_c & ~full_c;
        pop_c       = (state_q == ST_IDLE) & ~empty_c & ~CLR_NM;
        clr_evt_c   = (state_q == ST_WAIT_CLR) & CLR_NM;
        head_c      = fifo_mem[rd_ptr_q];
    end

    always_ff @(posedge SYS_CLOCK) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= WR_DATA[ENTRY_W-1:0];
        end
    end

    // Next-state, handshake outputs, flags and register reads
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        mosi_d     = mosi_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        newmsg_d   = newmsg_q;
        rxdata_d   = rxdata_q;
        rx_valid_d = rx_valid_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        irq_en_d   = irq_en_q;
        rd_data_d  = '0;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pop_c) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    mosi_d   = head_c[7:0];
                    addr_d   = head_c[14:8];
                    rw_d     = head_c[15];
                    newmsg_d = 1'b1;
                    state_d  = ST_WAIT_CLR;
                end
            end
            ST_WAIT_CLR: begin
                if (CLR_NM) begin
                    newmsg_d = 1'b0;
                    state_d  = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                if (!CLR_NM) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_WAIT_REL;
        endcase

        // Clears first so that a coincident set wins
        if (status_wr_c) begin
            if (WR_DATA[1]) rx_valid_d = 1'b0;
            if (WR_DATA[4]) ovf_d      = 1'b0;
            if (WR_DATA[5]) done_d     = 1'b0;
        end
        if (rxdata_rd_c) begin
            rx_valid_d = 1'b0;
        end
        if (cmd_wr_c && full_c) begin
            ovf_d = 1'b1;
        end
        if (clr_evt_c) begin
            done_d = 1'b1;
            if (rw_q) begin
                rxdata_d   = MISO;
                rx_valid_d = 1'b1;
            end
        end
        if (ctrl_wr_c) begin
            irq_en_d = WR_DATA[0];
        end

        if (rd_c) begin
            unique case (REG_ADDR)
                2'd1: begin
                    rd_data_d[0]           = newmsg_q | ~empty_c;
                    rd_data_d[1]           = rx_valid_q;
                    rd_data_d[2]           = full_c;
                    rd_data_d[3]           = empty_c;
                    rd_data_d[4]           = ovf_q;
                    rd_data_d[5]           = done_q;
                    rd_data_d[8 +: CNT_W]  = count_q;
                end
                2'd2:    rd_data_d[7:0] = rxdata_q;
                2'd3:    rd_data_d[0]   = irq_en_q;
                default: rd_data_d      = '0;
            endcase
        end

        irq_d = irq_en_d & done_d;
    end

    // The downstream controller keeps its state across our reset, hence WAIT_REL
    always_ff @(posedge SYS_CLOCK) begin
        if (RST) begin
            state_q    <= ST_WAIT_REL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mosi_q     <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            newmsg_q   <= 1'b0;
            rxdata_q   <= '0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mosi_q     <= mosi_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            newmsg_q   <= newmsg_d;
            rxdata_q   <= rxdata_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign RD_DATA    = rd_data_q;
    assign MOSI       = mosi_q;
    assign SLAVE_ADDR = addr_q;
    assign RW         = rw_q;
    assign NEWMSG     = newmsg_q;
    assign IRQ        = irq_q;

endmodule

// File: tb/tb_i2c_mmio_bridge.sv
// Directed bench for i2c_mmio_bridge: a per-cycle vector table for register and
// single-transfer behaviour, then hand sequences for FIFO, reset and race cases.
module tb_i2c_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [1:0]  reg_addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [7:0]  mosi;
    logic [6:0]  slave_addr;
    logic        rw;
    logic        newmsg;
    logic [7:0]  miso;
    logic        clr_nm;
    logic        irq;

    int checks = 0;
    int errors = 0;

    i2c_mmio_bridge #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
        .SYS_CLOCK (clk),
        .RST       (rst),
        .SEL       (sel),
        .REG_ADDR  (reg_addr),
        .WR_EN     (wr_en),
        .RD_EN     (rd_en),
        .WR_DATA   (wr_data),
        .RD_DATA   (rd_data),
        .MOSI      (mosi),
        .SLAVE_ADDR(slave_addr),
        .RW        (rw),
        .NEWMSG    (newmsg),
        .MISO      (miso),
        .CLR_NM    (clr_nm),
        .IRQ       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [1:0]  addr;
        logic        wr;
        logic        rd;
        logic [31:0] wdata;
        logic        clr;
        logic [7:0]  miso;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_nm;
        logic        exp_irq;
        logic [15:0] exp_cmd;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic s, input logic [1:0] a, input logic w,
                                input logic r, input logic [31:0] wd, input logic c,
                                input logic [7:0] mi, input logic cr,
                                input logic [31:0] er, input logic en,
                                input logic ei, input logic [15:0] ec);
        vec_t v;
        v.sel = s; v.addr = a; v.wr = w; v.rd = r; v.wdata = wd; v.clr = c;
        v.miso = mi; v.chk_rd = cr; v.exp_rd = er; v.exp_nm = en;
        v.exp_irq = ei; v.exp_cmd = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; wr_en = 1'b1; reg_addr = a; wr_data = d;
        tick();
        sel = 1'b0; wr_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        sel = 1'b1; rd_en = 1'b1; reg_addr = a;
        tick();
        d = rd_data;
        sel = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wait_nm(input string name);
        int n = 0;
        while (!newmsg && n < 10) begin
            tick();
            n++;
        end
        check(name, 32'(newmsg), 32'd1);
    endtask

    task automatic complete(input logic [7:0] m);
        miso = m; clr_nm = 1'b1;
        tick();
        check("nm_drop", 32'(newmsg), 32'd0);
        clr_nm = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [15:0] q2 [5];
        logic [15:0] q6 [4];

        // Per-cycle vectors: registers, a read transfer, a write-only transfer with IRQ
        vecs[0]  = mk(1, 2'd1, 0, 1, 32'h0,      0, 8'h00, 1, 32'h0000_0008, 0, 0, 16'h0000);
        vecs[1]  = mk(1, 2'd3, 0, 1, 32'h0,      0, 8'h00, 1, 32'h0000_0000, 0, 0, 16'h0000);
        vecs[2]  = mk(1, 2'd3, 1, 0, 32'h1,      0, 8'h00, 0, 32'h0,         0, 0, 16'h0000);
        vecs[3]  = mk(1, 2'd3, 0, 1, 32'h0,      0, 8'h00, 1, 32'h0000_0001, 0, 0, 16'h0000);
        vecs[4]  = mk(1, 2'd0, 1, 0, 32'hA53C,   0, 8'h00, 0, 32'h0,         0, 0, 16'h0000);
        vecs[5]  = mk(1, 2'd1, 0, 1, 32'h0,      0, 8'h00, 1, 32'h0000_0101, 1, 0, 16'hA53C);
        vecs[6]  = mk(1, 2'd1, 0, 1, 32'h0,      0, 8'h00, 1, 32'h0000_0009, 1, 0, 16'hA53C);
        vecs[7]  = mk(0, 2'd0, 0, 0, 32'h0,      1, 8'h5A, 0, 32'h0,         0, 1, 16'hA53C);
        vecs[8]  = mk(1, 2'd1, 0, 1, 32'h0,      1, 8'h00, 1, 32'h0000_002A, 0, 1, 16'hA53C);
        vecs[9]  = mk(1, 2'd2, 0, 1, 32'h0,      0, 8'h00, 1, 32'h0000_005A, 0, 1, 16'hA53C);
        vecs[10] = mk(1, 2'd1, 0, 1, 32'h0,      0, 8'h00, 1, 32'h0000_0028, 0, 1, 16'hA53C);
        vecs[11] = mk(1, 2'd1, 1, 0, 32'h20,     0, 8'h00, 0, 32'h0,         0, 0, 16'hA53C);
        vecs[12] = mk(1, 2'd1, 0, 1, 32'h0,      0, 8'h00, 1, 32'h0000_0008, 0, 0, 16'hA53C);
        vecs[13] = mk(1, 2'd0, 1, 0, 32'h1181,   0, 8'h00, 0, 32'h0,         0, 0, 16'hA53C);
        vecs[14] = mk(0, 2'd0, 0, 0, 32'h0,      0, 8'h00, 0, 32'h0,         1, 0, 16'h1181);
        vecs[15] = mk(0, 2'd0, 0, 0, 32'h0,      1, 8'hEE, 0, 32'h0,         0, 1, 16'h1181);
        vecs[16] = mk(1, 2'd1, 0, 1, 32'h0,      0, 8'h00, 1, 32'h0000_0028, 0, 1, 16'h1181);
        vecs[17] = mk(1, 2'd2, 0, 1, 32'h0,      0, 8'h00, 1, 32'h0000_005A, 0, 1, 16'h1181);
        vecs[18] = mk(1, 2'd1, 1, 0, 32'h20,     0, 8'h00, 0, 32'h0,         0, 0, 16'h1181);
        vecs[19] = mk(1, 2'd1, 0, 1, 32'h0,      0, 8'h00, 1, 32'h0000_0008, 0, 0, 16'h1181);
        vecs[20] = mk(0, 2'd1, 0, 1, 32'h0,      0, 8'h00, 1, 32'h0000_0000, 0, 0, 16'h1181);

        q2[0] = 16'h30A0; q2[1] = 16'hB1A1; q2[2] = 16'h32A2; q2[3] = 16'hB3A3; q2[4] = 16'h34A4;
        q6[0] = 16'h0161; q6[1] = 16'h0262; q6[2] = 16'h0363; q6[3] = 16'h0464;

        rst = 1'b1; sel = 1'b0; reg_addr = 2'd0; wr_en = 1'b0; rd_en = 1'b0;
        wr_data = '0; miso = '0; clr_nm = 1'b0;
        tick(); tick();
        check("rst_newmsg", 32'(newmsg), 32'd0);
        check("rst_cmd", 32'({rw, slave_addr, mosi}), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            sel = vecs[i].sel; reg_addr = vecs[i].addr; wr_en = vecs[i].wr;
            rd_en = vecs[i].rd; wr_data = vecs[i].wdata; clr_nm = vecs[i].clr;
            miso = vecs[i].miso;
            tick();
            check($sformatf("vec%0d_newmsg", i), 32'(newmsg), 32'(vecs[i].exp_nm));
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
            check($sformatf("vec%0d_cmd", i), 32'({rw, slave_addr, mosi}), 32'(vecs[i].exp_cmd));
            if (vecs[i].chk_rd) begin
                check($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
            end
        end
        sel = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_nm = 1'b0;

        // Back-to-back pushes with the controller stalled, then overflow and in-order drain
        for (int i = 0; i < 5; i++) bus_wr(2'd0, 32'(q2[i]));
        bus_rd(2'd1, d);
        check("fill_status", d, 32'h0000_0405);
        check("fill_inflight", 32'({rw, slave_addr, mosi}), 32'(q2[0]));
        bus_wr(2'd0, 32'h0000_B5A5);
        bus_rd(2'd1, d);
        check("ovf_status", d, 32'h0000_0415);
        for (int i = 0; i < 5; i++) begin
            wait_nm($sformatf("drain%0d_nm", i));
            check($sformatf("drain%0d_cmd", i), 32'({rw, slave_addr, mosi}), 32'(q2[i]));
            complete(8'h50 + 8'(i));
        end
        bus_rd(2'd1, d);
        check("drain_status", d, 32'h0000_003A);
        bus_rd(2'd2, d);
        check("drain_rxdata", d, 32'h0000_0053);
        bus_wr(2'd1, 32'h32);
        bus_rd(2'd1, d);
        check("drain_clear", d, 32'h0000_0008);

        // Push on full coinciding with a pop: push dropped
        clr_nm = 1'b1;
        for (int i = 0; i < 4; i++) bus_wr(2'd0, 32'(q6[i]));
        check("hold_nm", 32'(newmsg), 32'd0);
        clr_nm = 1'b0;
        bus_wr(2'd0, 32'h0000_0565);
        check("pushpop_nm", 32'(newmsg), 32'd1);
        check("pushpop_cmd", 32'({rw, slave_addr, mosi}), 32'(q6[0]));
        bus_rd(2'd1, d);
        check("pushpop_status", d, 32'h0000_0311);
        complete(8'h00);
        for (int i = 1; i < 4; i++) begin
            wait_nm($sformatf("pp%0d_nm", i));
            check($sformatf("pp%0d_cmd", i), 32'({rw, slave_addr, mosi}), 32'(q6[i]));
            complete(8'h00);
        end
        tick(); tick(); tick();
        check("dropped_never_sent", 32'(newmsg), 32'd0);
        bus_rd(2'd1, d);
        check("pp_status", d, 32'h0000_0038);
        bus_wr(2'd1, 32'h32);

        // CLR_NM rise coinciding with an RXDATA read
        bus_wr(2'd0, 32'h0000_C000);
        wait_nm("race1_nm");
        complete(8'h11);
        bus_wr(2'd0, 32'h0000_C100);
        wait_nm("race2_nm");
        clr_nm = 1'b1; miso = 8'h22;
        bus_rd(2'd2, d);
        check("race_old_byte", d, 32'h0000_0011);
        clr_nm = 1'b0;
        tick();
        bus_rd(2'd1, d);
        check("race_status", d, 32'h0000_002A);
        bus_rd(2'd2, d);
        check("race_new_byte", d, 32'h0000_0022);
        bus_wr(2'd1, 32'h20);
        bus_rd(2'd1, d);
        check("race_clear", d, 32'h0000_0008);

        // Reset while the controller still holds CLR_NM high
        bus_wr(2'd0, 32'h0000_1234);
        wait_nm("rst_pre_nm");
        check("rst_pre_cmd", 32'({rw, slave_addr, mosi}), 32'h1234);
        clr_nm = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_nm", 32'(newmsg), 32'd0);
        check("midrst_cmd", 32'({rw, slave_addr, mosi}), 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        bus_rd(2'd1, d);
        check("midrst_status", d, 32'h0000_0008);
        bus_rd(2'd3, d);
        check("midrst_ctrl", d, 32'h0000_0000);
        bus_wr(2'd0, 32'h0000_0955);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("blocked%0d_nm", i), 32'(newmsg), 32'd0);
        end
        clr_nm = 1'b0;
        tick();
        check("release_nm", 32'(newmsg), 32'd0);
        tick();
        check("launch_nm", 32'(newmsg), 32'd1);
        check("launch_cmd", 32'({rw, slave_addr, mosi}), 32'h0955);
        complete(8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
